// File: rtl/operand_fwd_unit.sv
// Operand forwarding unit: resolves NUM_SRC EX operands from RF, EX/MEM, MEM/WB and a
// one-entry write-back delay buffer, and sequences load-use stalls. Define
// OPERAND_FWD_STATS_EN to add saturating forwarding/stall statistics counters.
module operand_fwd_unit #(
  parameter int XLEN              = 64,
  parameter int NUM_SRC           = 2,
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          hold_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src_i,
  input  logic [NUM_SRC*XLEN-1:0]       ex_rf_val_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]            id_use_i,
  input  logic [REG_ADDR_W-1:0]         idex_rd_i,
  input  logic                          idex_memread_i,
  input  logic [REG_ADDR_W-1:0]         exmem_rd_i,
  input  logic                          exmem_regwrite_i,
  input  logic [XLEN-1:0]               exmem_val_i,
  input  logic [REG_ADDR_W-1:0]         memwb_rd_i,
  input  logic                          memwb_regwrite_i,
  input  logic [XLEN-1:0]               memwb_val_i,
  output logic [NUM_SRC*XLEN-1:0]       op_val_o,
  output logic [NUM_SRC*2-1:0]          fwd_sel_o,
  output logic                          stall_o,
  output logic                          bubble_o
`ifdef OPERAND_FWD_STATS_EN
  ,
  output logic [31:0]                   fwd_exmem_cnt_o,
  output logic [31:0]                   fwd_memwb_cnt_o,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_MEMWB = 2'b01;
  localparam logic [1:0] SEL_EXMEM = 2'b10;
  localparam logic [1:0] SEL_WBD   = 2'b11;

  typedef enum logic {RUN, STALL} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  wbd_valid;
  logic [REG_ADDR_W-1:0] wbd_rd;
  logic [XLEN-1:0]       wbd_val;
  logic                  hazard;

  // Youngest producer wins; x0 is never forwarded so its RF value passes through.
  always_comb begin
    fwd_sel_o = '0;
    op_val_o  = ex_rf_val_i;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_src_i[i*REG_ADDR_W +: REG_ADDR_W] != '0) begin
        if (exmem_regwrite_i && exmem_rd_i != '0 &&
            exmem_rd_i == ex_src_i[i*REG_ADDR_W +: REG_ADDR_W]) begin
          fwd_sel_o[i*2 +: 2]      = SEL_EXMEM;
          op_val_o[i*XLEN +: XLEN] = exmem_val_i;
        end else if (memwb_regwrite_i && memwb_rd_i != '0 &&
                     memwb_rd_i == ex_src_i[i*REG_ADDR_W +: REG_ADDR_W]) begin
          fwd_sel_o[i*2 +: 2]      = SEL_MEMWB;
          op_val_o[i*XLEN +: XLEN] = memwb_val_i;
        end else if (wbd_valid && wbd_rd == ex_src_i[i*REG_ADDR_W +: REG_ADDR_W]) begin
          fwd_sel_o[i*2 +: 2]      = SEL_WBD;
          op_val_o[i*XLEN +: XLEN] = wbd_val;
        end else begin
          fwd_sel_o[i*2 +: 2]      = SEL_RF;
        end
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    if (idex_memread_i && idex_rd_i != '0) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (id_use_i[i] && id_src_i[i*REG_ADDR_W +: REG_ADDR_W] == idex_rd_i)
          hazard = 1'b1;
      end
    end
  end

  // While counting down, the load has already left EX, so new hazards are not re-evaluated.
  assign stall_o  = (state == STALL) || hazard;
  assign bubble_o = stall_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      cnt       <= '0;
      wbd_valid <= 1'b0;
      wbd_rd    <= '0;
      wbd_val   <= '0;
    end else if (!hold_i) begin
      if (memwb_regwrite_i && memwb_rd_i != '0) begin
        wbd_valid <= 1'b1;
        wbd_rd    <= memwb_rd_i;
        wbd_val   <= memwb_val_i;
      end else begin
        wbd_valid <= 1'b0;
      end
      case (state)
        RUN: begin
          if (hazard && LOAD_STALL_CYCLES > 1) begin
            cnt   <= 4'(LOAD_STALL_CYCLES - 1);
            state <= STALL;
          end
        end
        STALL: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef OPERAND_FWD_STATS_EN
  logic [2:0] n_exmem;
  logic [2:0] n_memwb;

  always_comb begin
    n_exmem = '0;
    n_memwb = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (fwd_sel_o[i*2 +: 2])
        SEL_EXMEM:        n_exmem = n_exmem + 3'd1;
        SEL_MEMWB, SEL_WBD: n_memwb = n_memwb + 3'd1;
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {30'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_exmem_cnt_o <= '0;
      fwd_memwb_cnt_o <= '0;
      stall_cnt_o     <= '0;
    end else if (!hold_i) begin
      if (!bubble_o) begin
        fwd_exmem_cnt_o <= sat_add(fwd_exmem_cnt_o, n_exmem);
        fwd_memwb_cnt_o <= sat_add(fwd_memwb_cnt_o, n_memwb);
      end
      if (stall_o)
        stall_cnt_o <= sat_add(stall_cnt_o, 3'd1);
    end
  end
`endif

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Testbench for operand_fwd_unit: directed scenarios plus a randomized phase, checked
// against a register-transfer-free reference model (two instances, 3- and 2-cycle stalls).
module tb_operand_fwd_unit;

  localparam int XLEN = 64;
  localparam int NS   = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            hold;
  logic [AW-1:0]   ex_src [NS];
  logic [XLEN-1:0] rf_val [NS];
  logic [AW-1:0]   id_src [NS];
  logic [NS-1:0]   id_use;
  logic [AW-1:0]   idex_rd, exmem_rd, memwb_rd;
  logic            idex_memread, exmem_we, memwb_we;
  logic [XLEN-1:0] exmem_val, memwb_val;

  logic [NS*AW-1:0]   ex_src_bus, id_src_bus;
  logic [NS*XLEN-1:0] rf_val_bus;
  assign ex_src_bus = {ex_src[1], ex_src[0]};
  assign id_src_bus = {id_src[1], id_src[0]};
  assign rf_val_bus = {rf_val[1], rf_val[0]};

  logic [NS*XLEN-1:0] op3, op2;
  logic [NS*2-1:0]    sel3, sel2;
  logic               stall3, bubble3, stall2, bubble2;
`ifdef OPERAND_FWD_STATS_EN
  logic [31:0] exc3, mwc3, stc3, exc2, mwc2, stc2;
`endif

  operand_fwd_unit #(.XLEN(XLEN), .NUM_SRC(NS), .REG_ADDR_W(AW), .LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hold_i(hold),
    .ex_src_i(ex_src_bus), .ex_rf_val_i(rf_val_bus),
    .id_src_i(id_src_bus), .id_use_i(id_use),
    .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
    .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_we), .exmem_val_i(exmem_val),
    .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_we), .memwb_val_i(memwb_val),
    .op_val_o(op3), .fwd_sel_o(sel3), .stall_o(stall3), .bubble_o(bubble3)
`ifdef OPERAND_FWD_STATS_EN
    , .fwd_exmem_cnt_o(exc3), .fwd_memwb_cnt_o(mwc3), .stall_cnt_o(stc3)
`endif
  );

  operand_fwd_unit #(.XLEN(XLEN), .NUM_SRC(NS), .REG_ADDR_W(AW), .LOAD_STALL_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .hold_i(hold),
    .ex_src_i(ex_src_bus), .ex_rf_val_i(rf_val_bus),
    .id_src_i(id_src_bus), .id_use_i(id_use),
    .idex_rd_i(idex_rd), .idex_memread_i(idex_memread),
    .exmem_rd_i(exmem_rd), .exmem_regwrite_i(exmem_we), .exmem_val_i(exmem_val),
    .memwb_rd_i(memwb_rd), .memwb_regwrite_i(memwb_we), .memwb_val_i(memwb_val),
    .op_val_o(op2), .fwd_sel_o(sel2), .stall_o(stall2), .bubble_o(bubble2)
`ifdef OPERAND_FWD_STATS_EN
    , .fwd_exmem_cnt_o(exc2), .fwd_memwb_cnt_o(mwc2), .stall_cnt_o(stc2)
`endif
  );

  // Reference model: last committed write-back and stall cycles still owed per instance.
  logic            m_wbd_valid;
  logic [AW-1:0]   m_wbd_rd;
  logic [XLEN-1:0] m_wbd_val;
  int              owed3, owed2;
  int              checks = 0;
  int              errors = 0;
  int              seen3, seen2;

  function automatic logic modelHazard();
    logic hz = 1'b0;
    if (idex_memread && idex_rd != 0)
      for (int i = 0; i < NS; i++)
        if (id_use[i] && id_src[i] == idex_rd) hz = 1'b1;
    return hz;
  endfunction

  function automatic logic [1:0] expSel(int i);
    if (ex_src[i] == 0) return 2'b00;
    if (exmem_we && exmem_rd == ex_src[i]) return 2'b10;
    if (memwb_we && memwb_rd == ex_src[i]) return 2'b01;
    if (m_wbd_valid && m_wbd_rd == ex_src[i]) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [XLEN-1:0] expVal(int i);
    case (expSel(i))
      2'b10:   return exmem_val;
      2'b01:   return memwb_val;
      2'b11:   return m_wbd_val;
      default: return rf_val[i];
    endcase
  endfunction

  function automatic int nextOwed(int owed, logic hz, int total);
    if (owed > 0) return owed - 1;
    if (hz) return total - 1;
    return 0;
  endfunction

  task automatic checkValue(string tag, logic [63:0] observed, logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(string tag);
    logic hz;
    hz = modelHazard();
    for (int i = 0; i < NS; i++) begin
      checkValue($sformatf("%s.sel3_%0d", tag, i), {62'b0, sel3[i*2 +: 2]}, {62'b0, expSel(i)});
      checkValue($sformatf("%s.op3_%0d", tag, i), op3[i*XLEN +: XLEN], expVal(i));
      checkValue($sformatf("%s.sel2_%0d", tag, i), {62'b0, sel2[i*2 +: 2]}, {62'b0, expSel(i)});
      checkValue($sformatf("%s.op2_%0d", tag, i), op2[i*XLEN +: XLEN], expVal(i));
    end
    checkValue({tag, ".stall3"},  {63'b0, stall3},  {63'b0, (owed3 > 0) || hz});
    checkValue({tag, ".bubble3"}, {63'b0, bubble3}, {63'b0, (owed3 > 0) || hz});
    checkValue({tag, ".stall2"},  {63'b0, stall2},  {63'b0, (owed2 > 0) || hz});
    checkValue({tag, ".bubble2"}, {63'b0, bubble2}, {63'b0, (owed2 > 0) || hz});
  endtask

  task automatic applyStimulus(bit randomize);
    hold         = randomize ? ($urandom_range(0, 4) == 0) : 1'b0;
    idex_memread = randomize ? 1'($urandom_range(0, 1)) : 1'b0;
    idex_rd      = randomize ? AW'($urandom_range(0, 7)) : '0;
    exmem_we     = randomize ? 1'($urandom_range(0, 1)) : 1'b0;
    exmem_rd     = randomize ? AW'($urandom_range(0, 7)) : '0;
    exmem_val    = randomize ? {$urandom, $urandom} : '0;
    memwb_we     = randomize ? 1'($urandom_range(0, 1)) : 1'b0;
    memwb_rd     = randomize ? AW'($urandom_range(0, 7)) : '0;
    memwb_val    = randomize ? {$urandom, $urandom} : '0;
    id_use       = randomize ? NS'($urandom_range(0, 3)) : '0;
    for (int i = 0; i < NS; i++) begin
      ex_src[i] = randomize ? AW'($urandom_range(0, 7)) : '0;
      id_src[i] = randomize ? AW'($urandom_range(0, 7)) : '0;
      rf_val[i] = {$urandom, $urandom};
    end
    #1;
  endtask

  // Advance the model with the inputs present before the edge, then clock the DUTs.
  task automatic tick();
    logic hz;
    hz = modelHazard();
    if (!rst_n) begin
      m_wbd_valid = 1'b0;
      m_wbd_rd    = '0;
      m_wbd_val   = '0;
      owed3       = 0;
      owed2       = 0;
    end else if (!hold) begin
      owed3       = nextOwed(owed3, hz, 3);
      owed2       = nextOwed(owed2, hz, 2);
      m_wbd_valid = memwb_we && memwb_rd != 0;
      if (m_wbd_valid) begin
        m_wbd_rd  = memwb_rd;
        m_wbd_val = memwb_val;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_wbd_valid = 1'b0; m_wbd_rd = '0; m_wbd_val = '0; owed3 = 0; owed2 = 0;
    rst_n = 1'b0;
    applyStimulus(0);
    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] reset and x0 guard");
    applyStimulus(0);
    exmem_we = 1'b1; exmem_rd = '0; exmem_val = 64'hDEAD;
    #1;
    checkOutput("reset");
    checkValue("x0_sel", {62'b0, sel3[1:0]}, 64'h0);
    checkValue("x0_op", op3[XLEN-1:0], rf_val[0]);
    checkValue("x0_stall", {63'b0, stall3}, 64'h0);

    $display("[TB] priority");
    applyStimulus(0);
    memwb_we = 1'b1; memwb_rd = 5'd5; memwb_val = 64'h33;
    #1;
    checkOutput("prio_fill");
    tick();
    ex_src[0] = 5'd5;
    exmem_we = 1'b1; exmem_rd = 5'd5; exmem_val = 64'h11;
    memwb_we = 1'b1; memwb_rd = 5'd5; memwb_val = 64'h22;
    #1;
    checkOutput("prio_all");
    checkValue("prio_exmem_sel", {62'b0, sel3[1:0]}, 64'h2);
    checkValue("prio_exmem_op", op3[XLEN-1:0], 64'h11);
    exmem_we = 1'b0;
    #1;
    checkValue("prio_memwb_sel", {62'b0, sel3[1:0]}, 64'h1);
    checkValue("prio_memwb_op", op3[XLEN-1:0], 64'h22);
    memwb_we = 1'b0;
    #1;
    checkValue("prio_wbd_sel", {62'b0, sel3[1:0]}, 64'h3);
    checkValue("prio_wbd_op", op3[XLEN-1:0], 64'h33);

    $display("[TB] write-back delay");
    applyStimulus(0);
    memwb_we = 1'b1; memwb_rd = 5'd7; memwb_val = 64'hABCD;
    #1;
    tick();
    applyStimulus(0);
    ex_src[1] = 5'd7;
    #1;
    checkOutput("wbd_n1");
    checkValue("wbd_n1_sel", {62'b0, sel3[3:2]}, 64'h3);
    checkValue("wbd_n1_op", op3[2*XLEN-1:XLEN], 64'hABCD);
    tick();
    checkOutput("wbd_n2");
    checkValue("wbd_n2_sel", {62'b0, sel3[3:2]}, 64'h0);

    $display("[TB] load-use");
    applyStimulus(0);
    idex_memread = 1'b1; idex_rd = 5'd9; id_src[0] = 5'd9; id_use = 2'b01;
    #1;
    seen3 = 0; seen2 = 0;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("lu_c%0d", c));
      seen3 += int'(stall3);
      seen2 += int'(stall2);
      tick();
      idex_memread = 1'b0;
      #1;
    end
    checkValue("lu_len3", 64'(seen3), 64'd3);
    checkValue("lu_len2", 64'(seen2), 64'd2);
    idex_memread = 1'b1; id_use = 2'b00;
    #1;
    checkOutput("lu_nouse");
    checkValue("lu_nouse_stall", {63'b0, stall3}, 64'h0);
    tick();

    $display("[TB] hold during stall");
    applyStimulus(0);
    idex_memread = 1'b1; idex_rd = 5'd4; id_src[1] = 5'd4; id_use = 2'b10;
    #1;
    seen3 = 0; seen2 = 0;
    for (int c = 0; c < 8; c++) begin
      checkOutput($sformatf("hold_c%0d", c));
      seen3 += int'(stall3);
      seen2 += int'(stall2);
      tick();
      idex_memread = 1'b0;
      hold = (c < 4);
      #1;
    end
    checkValue("hold_len2", 64'(seen2), 64'd6);
    checkValue("hold_len3", 64'(seen3), 64'd7);

    $display("[TB] reset mid-stall");
    applyStimulus(0);
    idex_memread = 1'b1; idex_rd = 5'd9; id_src[0] = 5'd9; id_use = 2'b01;
    #1;
    checkOutput("rms_c1");
    tick();
    idex_memread = 1'b0;
    #1;
    checkOutput("rms_c2");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rms_after");
    checkValue("rms_stall3", {63'b0, stall3}, 64'h0);
`ifdef OPERAND_FWD_STATS_EN
    checkValue("rms_exc", {32'b0, exc3}, 64'h0);
    checkValue("rms_mwc", {32'b0, mwc3}, 64'h0);
    checkValue("rms_stc", {32'b0, stc3}, 64'h0);
`endif

    $display("[TB] randomized");
    for (int c = 0; c < 400; c++) begin
      applyStimulus(1);
      rst_n = ($urandom_range(0, 49) != 0);
      #1;
      checkOutput($sformatf("rand%0d", c));
      tick();
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fwd_unit.md
Name: operand_fwd_unit

Overview:
- Parametrised successor to the two-source 3:1 operand forwarding mux in the RISC-V pipeline.
- Resolves up to NUM_SRC EX-stage operands from four sources: register file, EX/MEM, MEM/WB, and a one-entry write-back delay buffer.
- Adds load-use hazard detection with a counted stall/bubble sequencer for multi-cycle data memory.
- Sits between the ID/EX pipeline register and the ALU operand inputs; drives stall and bubble to the pipeline control.

Parameters:
- XLEN, 64, datapath width in bits.
- NUM_SRC, 2, number of source operands resolved in parallel (1..4).
- REG_ADDR_W, 5, register index width.
- LOAD_STALL_CYCLES, 1, stall cycles inserted per load-use hazard (1..15).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- hold_i  in  1  global pipeline freeze; all internal state holds.
- ex_src_i  in  NUM_SRC*REG_ADDR_W  EX-stage source indices, operand i at bits [i*REG_ADDR_W +: REG_ADDR_W].
- ex_rf_val_i  in  NUM_SRC*XLEN  register-file values read in ID for each operand.
- id_src_i  in  NUM_SRC*REG_ADDR_W  ID-stage source indices, used for load-use detection.
- id_use_i  in  NUM_SRC  per-operand "actually read" mask for the ID instruction.
- idex_rd_i, idex_memread_i  in  REG_ADDR_W, 1  destination register and load flag of the instruction in EX.
- exmem_rd_i, exmem_regwrite_i, exmem_val_i  in  REG_ADDR_W, 1, XLEN  EX/MEM writer.
- memwb_rd_i, memwb_regwrite_i, memwb_val_i  in  REG_ADDR_W, 1, XLEN  MEM/WB writer.
- op_val_o  out  NUM_SRC*XLEN  resolved operand values.
- fwd_sel_o  out  NUM_SRC*2  per-operand select: 00 rf, 01 MEM/WB, 10 EX/MEM, 11 WB-delay.
- stall_o  out  1  freeze PC and IF/ID.
- bubble_o  out  1  insert NOP into ID/EX.

Behaviour:
- Reset (rst_n=0 at clk edge): stall counter = 0, wbd_valid = 0, wbd_rd = 0, wbd_val = 0.
- Reset output values: stall_o = 0, bubble_o = 0. Selects follow from combinational logic with wbd cleared.
- A reset mid-stall aborts the stall sequence immediately.
- Operand select, evaluated combinationally per operand with priority in this order:
  - EX/MEM: exmem_regwrite_i && exmem_rd_i != 0 && exmem_rd_i == src.
  - MEM/WB: memwb_regwrite_i && memwb_rd_i != 0 && match.
  - WB-delay: wbd_valid && wbd_rd == src.
  - Otherwise the register file.
- src == 0 always selects 00 and outputs ex_rf_val_i unmodified.
- Selection latency is 0 cycles, combinational.
- WB-delay buffer, updated each edge when hold_i=0:
  - If memwb_regwrite_i && memwb_rd_i != 0: wbd_valid <= 1, wbd_rd <= memwb_rd_i, wbd_val <= memwb_val_i.
  - Otherwise wbd_valid <= 0.
  - Purpose: covers a register-file write in the same cycle as the read.
- Load-use hazard: idex_memread_i && idex_rd_i != 0 && for some i, id_use_i[i] && id_src_i[i] == idex_rd_i.
- Stall sequencer, states RUN (cnt == 0) and STALL (cnt != 0):
  - In RUN, a hazard sets stall_o = bubble_o = 1 that cycle. Next cnt = LOAD_STALL_CYCLES-1.
  - In STALL, stall_o = bubble_o = 1 and cnt decrements each non-held edge. Returns to RUN at 0.
  - Hazard detection is ignored while in STALL. The load has advanced by then, and forwarding covers it on exit.
  - LOAD_STALL_CYCLES=1 never enters STALL: a single one-cycle pulse.
- hold_i=1: cnt and the wbd registers keep their value. stall_o and bubble_o still reflect the current state and hazard.
- Simultaneous EX/MEM and MEM/WB writes to the same rd: EX/MEM wins (youngest).

Optional Feature:
- Macro: OPERAND_FWD_STATS_EN.
- When defined, adds three 32-bit counters, each readable as an output:
  - fwd_exmem_cnt_o: counts operands selecting 10 per non-held, non-bubble cycle.
  - fwd_memwb_cnt_o: counts operands selecting 01 or 11, under the same qualification.
  - stall_cnt_o: counts cycles with stall_o=1.
- Counters saturate at 0xFFFFFFFF and clear on reset.
- Without the macro: no counters, no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset and x0 guard:
  - Stimulus: rst_n=0 for 2 cycles, then ex_src=0 with exmem_rd=0, exmem_regwrite=1, exmem_val=0xDEAD.
  - Required: fwd_sel=00, op_val=ex_rf_val, stall_o=0.
- Priority:
  - Stimulus: ex_src[0]=5; exmem_rd=5 (val 0x11); memwb_rd=5 (val 0x22); wbd holds rd 5.
  - Required: sel=10, op=0x11. Drop exmem_regwrite: sel=01, op=0x22.
- WB-delay:
  - Stimulus: memwb writes x7=0xABCD in cycle N; cycle N+1 has no writers and ex_src[1]=7.
  - Required: sel=11, op=0xABCD. Cycle N+2: sel=00.
- Load-use, LOAD_STALL_CYCLES=3:
  - Stimulus: idex_memread=1, idex_rd=9, id_src[0]=9, id_use=01.
  - Required: stall_o=bubble_o=1 for exactly 3 cycles, then 0. With id_use=00: no stall.
- Hold during stall:
  - Stimulus: LOAD_STALL_CYCLES=2, hold_i=1 for 4 cycles after the hazard.
  - Required: stall_o stays 1 for 4+2 cycles total.
- Reset mid-stall:
  - Stimulus: rst_n=0 during cycle 2 of a 3-cycle stall.
  - Required: stall_o=0 on the next cycle, and with OPERAND_FWD_STATS_EN defined all counters read 0.
